// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the elastic pipeline.
package pipe_pkg;

    localparam int PIPE_MAX_STAGES = 8;
    localparam int PIPE_STAT_W     = 32;

    // Saturating increment used by the statistics counter.
    function automatic logic [PIPE_STAT_W-1:0] sat_inc(input logic [PIPE_STAT_W-1:0] value);
        return (&value) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One valid/data register of the elastic pipeline; load wins over drain/flush.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             kill,
    input  logic             flush,
    input  logic             drain,
    input  logic [WIDTH-1:0] load_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= ~kill;
            data  <= load_data;
        end else if (drain || flush) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pipe_elastic.sv
// Elastic valid/ready register pipeline with per-stage flush and input kill.
// Optional statistics outputs are built when PIPE_ELASTIC_STATS_EN is defined.
module pipe_elastic
    import pipe_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              in_kill,
    input  logic [STAGES-1:0] flush_mask,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data
`ifdef PIPE_ELASTIC_STATS_EN
    ,
    output logic [$clog2(STAGES+1)-1:0] occupancy,
    output logic [PIPE_STAT_W-1:0]      stall_cnt
`endif
);

    localparam int LAST = STAGES - 1;

    if (STAGES < 1 || STAGES > PIPE_MAX_STAGES) begin : g_bad_stages
        $error("pipe_elastic: STAGES out of range");
    end

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] adv;
    logic [WIDTH-1:0]  d [STAGES];

    assign out_valid = v[LAST] & ~flush_mask[LAST];
    assign out_data  = d[LAST];
    assign in_ready  = ~v[0] | adv[0];

    // Walk from the output end: a stage moves when the one ahead is empty or moving.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        logic space;
        adv       = '0;
        adv[LAST] = out_valid & out_ready;
        space     = ~v[LAST] | adv[LAST];
        for (int i = STAGES - 2; i >= 0; i--) begin
            adv[i] = v[i] & space;
            space  = ~v[i] | adv[i];
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        logic             load;
        logic             kill;
        logic [WIDTH-1:0] load_data;

        if (g == 0) begin : g_head
            assign load      = in_valid & in_ready;
            assign kill      = in_kill;
            assign load_data = in_data;
        end else begin : g_body
            // A flushed item still moves forward, but arrives as a bubble.
            assign load      = adv[g-1];
            assign kill      = flush_mask[g-1];
            assign load_data = d[g-1];
        end

        pipe_stage #(.WIDTH(WIDTH)) u_stage (
            .clk       (clk),
            .rst       (rst),
            .load      (load),
            .kill      (kill),
            .flush     (flush_mask[g]),
            .drain     (adv[g]),
            .load_data (load_data),
            .valid     (v[g]),
            .data      (d[g])
        );
    end

`ifdef PIPE_ELASTIC_STATS_EN
    localparam int OCC_W = $clog2(STAGES + 1);

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < STAGES; i++) begin
            occupancy = occupancy + OCC_W'(v[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready) begin
            stall_cnt <= sat_inc(stall_cnt);
        end
    end
`else
    // Statistics outputs and counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_pipe_elastic.sv
// Self-checking bench for pipe_elastic: directed scenarios plus random traffic vs a slot model.
// Statistics checks are compiled in when PIPE_ELASTIC_STATS_EN is defined.
module tb_pipe_elastic;

    localparam int WIDTH  = 32;
    localparam int STAGES = 3;
    localparam int L      = STAGES - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [WIDTH-1:0]  in_data = '0;
    logic              in_kill = 1'b0;
    logic [STAGES-1:0] flush_mask = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [WIDTH-1:0]  out_data;
`ifdef PIPE_ELASTIC_STATS_EN
    logic [$clog2(STAGES+1)-1:0] occupancy;
    logic [31:0]                 stall_cnt;
`endif

    pipe_elastic #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_kill    (in_kill),
        .flush_mask (flush_mask),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data)
`ifdef PIPE_ELASTIC_STATS_EN
        ,
        .occupancy  (occupancy),
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: slots of the pipe, slot L nearest the output.
    bit               mv [STAGES];
    logic [WIDTH-1:0] md [STAGES];
    logic [31:0]      m_stall;
    int               stuck_from;
    bit               exp_ov;
    bit               exp_ir;
    bit               m_retire;
    logic [WIDTH-1:0] obs_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < STAGES; i++) begin
            mv[i] = 1'b0;
            md[i] = '0;
        end
        m_stall = '0;
    endtask

    // Items behind a blocked output form a stuck run; everything else shifts one slot.
    function automatic void model_eval();
        m_retire   = mv[L] && !flush_mask[L] && out_ready;
        exp_ov     = mv[L] && !flush_mask[L];
        stuck_from = STAGES;
        if (mv[L] && !m_retire) begin
            stuck_from = L;
            while (stuck_from > 0 && mv[stuck_from-1]) stuck_from--;
        end
        exp_ir = !mv[0] || (stuck_from > 0);
    endfunction

    task automatic model_commit();
        bit               nv [STAGES];
        logic [WIDTH-1:0] nd [STAGES];
        for (int i = 0; i < STAGES; i++) begin
            nv[i] = 1'b0;
            nd[i] = md[i];
        end
        for (int i = 0; i < STAGES; i++) begin
            if (mv[i]) begin
                if (i >= stuck_from) begin
                    nv[i] = !flush_mask[i];
                end else if (i < L) begin
                    nv[i+1] = !flush_mask[i];
                    nd[i+1] = md[i];
                end
            end
        end
        if (in_valid && exp_ir) begin
            nv[0] = !in_kill;
            nd[0] = in_data;
        end
        if (exp_ov && !out_ready && m_stall != 32'hFFFF_FFFF) m_stall++;
        for (int i = 0; i < STAGES; i++) begin
            mv[i] = nv[i];
            md[i] = nd[i];
        end
    endtask

    // Called at a falling edge with inputs already set; returns at the next falling edge.
    task automatic cycle();
        int occ;
        #1;
        model_eval();
        check("out_valid", 32'(out_valid), 32'(exp_ov));
        check("in_ready", 32'(in_ready), 32'(exp_ir));
        if (exp_ov) check("out_data", out_data, md[L]);
`ifdef PIPE_ELASTIC_STATS_EN
        occ = 0;
        for (int i = 0; i < STAGES; i++) occ += int'(mv[i]);
        check("occupancy", 32'(occupancy), 32'(occ));
        check("stall_cnt", stall_cnt, m_stall);
`else
        occ = 0;
`endif
        if (out_valid && out_ready) obs_q.push_back(out_data);
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        in_valid   = 1'b0;
        in_kill    = 1'b0;
        flush_mask = '0;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_data", out_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Streaming three items with the output always ready.
        out_ready = 1'b1;
        obs_q.delete();
        in_valid = 1'b1;
        in_data = 32'h11; cycle();
        in_data = 32'h22; cycle();
        in_data = 32'h33; cycle();
        idle_inputs();
        repeat (4) cycle();
        check("stream_count", 32'(obs_q.size()), 32'd3);
        if (obs_q.size() == 3) begin
            check("stream_0", obs_q[0], 32'h11);
            check("stream_1", obs_q[1], 32'h22);
            check("stream_2", obs_q[2], 32'h33);
        end

        // Fill, stall, then drain in order.
        obs_q.delete();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 32'hB1; cycle();
        in_data = 32'hB2; cycle();
        in_data = 32'hB3; cycle();
        #1;
        check("full_in_ready", 32'(in_ready), 32'd0);
        in_data = 32'hB4;
        @(negedge clk);
        repeat (3) cycle();
        idle_inputs();
        out_ready = 1'b1;
        repeat (5) cycle();
        check("drain_count", 32'(obs_q.size()), 32'd3);
        if (obs_q.size() == 3) begin
            check("drain_0", obs_q[0], 32'hB1);
            check("drain_1", obs_q[1], 32'hB2);
            check("drain_2", obs_q[2], 32'hB3);
        end

        // Full pipe, flush the two younger stages for one cycle.
        obs_q.delete();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 32'hA1; cycle();
        in_data = 32'hA2; cycle();
        in_data = 32'hA3; cycle();
        idle_inputs();
        out_ready = 1'b1;
        flush_mask = 3'b011;
        cycle();
        flush_mask = '0;
        repeat (4) cycle();
        check("flush_count", 32'(obs_q.size()), 32'd1);
        if (obs_q.size() == 1) check("flush_survivor", obs_q[0], 32'hA1);

        // Killed item: handshake completes, item never appears.
        obs_q.delete();
        in_valid = 1'b1;
        in_kill  = 1'b1;
        in_data  = 32'hAA;
        #1;
        check("kill_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        cycle();
        idle_inputs();
        repeat (4) cycle();
        check("kill_count", 32'(obs_q.size()), 32'd0);

        // Asynchronous reset with two items in flight.
        obs_q.delete();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 32'hC1; cycle();
        in_data = 32'hC2; cycle();
        cycle();
        #2;
        rst = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_hold_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        idle_inputs();
        repeat (4) cycle();
        check("rst_count", 32'(obs_q.size()), 32'd0);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            in_valid   = ($urandom_range(3) != 0);
            in_data    = $urandom;
            in_kill    = ($urandom_range(7) == 0);
            out_ready  = ($urandom_range(3) != 0);
            flush_mask = ($urandom_range(15) == 0) ? STAGES'($urandom) : '0;
            cycle();
        end
        idle_inputs();
        out_ready = 1'b1;
        repeat (STAGES + 1) cycle();

`ifdef PIPE_ELASTIC_STATS_EN
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 32'hD1; cycle();
        in_data = 32'hD2; cycle();
        in_data = 32'hD3; cycle();
        idle_inputs();
        repeat (5) cycle();
        #1;
        check("stats_occupancy", 32'(occupancy), 32'd3);
        check("stats_stall5", stall_cnt, 32'd5);
        force dut.stall_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt;
        m_stall = 32'hFFFF_FFFE;
        @(negedge clk);
        repeat (3) cycle();
        #1;
        check("stats_saturate", stall_cnt, 32'hFFFF_FFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pipe_elastic.md
PIPE_ELASTIC -- requirements
Module: pipe_elastic

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning payload bits per stage.
REQ-002 SHALL have parameter STAGES, default 3, meaning register stages; legal range 1..8.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, all state on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: upstream item present.
REQ-006 SHALL have port in_ready, output, 1 bit: stage 0 can accept.
REQ-007 SHALL have port in_data, input, WIDTH bits: upstream payload.
REQ-008 SHALL have port in_kill, input, 1 bit: item accepted this cycle is discarded.
REQ-009 SHALL have port flush_mask, input, STAGES bits: bit i discards the item held in stage i.
REQ-010 SHALL have port out_valid, output, 1 bit: last stage holds a live item.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts.
REQ-012 SHALL have port out_data, output, WIDTH bits: last-stage payload.

Function
REQ-013 Stage i SHALL hold a valid bit v[i] and a WIDTH-bit data register d[i]; stage 0 is the input end.
REQ-014 Stage i SHALL advance when it holds an item and stage i+1 is empty or advancing; the last stage advances on out_valid & out_ready.
REQ-015 in_ready SHALL be ~v[0] | advance[0], combinational from out_ready, so a full pipe with out_ready=1 sustains one item per cycle.
REQ-016 An input transfer SHALL occur on in_valid & in_ready; stage 0 then loads in_data with v[0] = ~in_kill.
REQ-017 Unobstructed latency SHALL be STAGES cycles: an item accepted at edge t is on out_data after edge t+STAGES-1 and retires at edge t+STAGES.
REQ-018 flush_mask[i]=1 SHALL clear the item in stage i at the next edge; if that item advances, stage i+1 loads with valid=0.
REQ-019 out_valid SHALL be v[STAGES-1] & ~flush_mask[STAGES-1]; a flushed last-stage item SHALL never be transferred.
REQ-020 Flush of stage i SHALL NOT affect items in other stages, and the input handshake SHALL still complete while flushes occur.
REQ-021 A stage not loading SHALL hold d[i] unchanged; d of invalid stages is don't-care.
REQ-022 out_data SHALL come directly from d[STAGES-1] with no combinational path from in_data.
REQ-023 When STAGES=1, stage 0 is also the last stage, and in_ready = ~v[0] | out_ready.

Reset
REQ-024 rst SHALL asynchronously clear all v[i] to 0, making out_valid=0 and in_ready=1.
REQ-025 d[i] SHALL reset to 0.
REQ-026 An item in flight when rst asserts SHALL be lost, and no transfer SHALL occur while rst is high.

Configuration
REQ-027 With macro PIPE_ELASTIC_STATS_EN defined, the block SHALL add outputs occupancy ($clog2(STAGES+1) bits, the live count of v[i]) and stall_cnt (32 bits).
REQ-028 stall_cnt SHALL increment on each cycle with out_valid & ~out_ready and saturate at 0xFFFFFFFF.
REQ-029 Both statistics outputs SHALL reset to 0.
REQ-030 Without PIPE_ELASTIC_STATS_EN, both ports and their logic SHALL be absent.

Structure
REQ-031 The shared package pipe_pkg SHALL hold PIPE_MAX_STAGES=8 and PIPE_STAT_W=32.
REQ-032 A sub-module pipe_stage SHALL implement one valid/data register, with load, kill and flush inputs, and SHALL be instantiated STAGES times by generate.

Verification
REQ-033 STAGES=3, out_ready=1, with in_data 0x11,0x22,0x33 on consecutive cycles -> out_data shows 0x11,0x22,0x33 on cycles 3,4,5, and in_ready stays 1.
REQ-034 Fill 3 items, then out_ready=0 for 4 cycles -> in_ready=0 after fill, and all data holds; with out_ready=1 the items drain in order with no loss or duplication.
REQ-035 Full pipe, with flush_mask=3'b011 for one cycle -> only the item from stage 2 retires, and the two younger items never appear.
REQ-036 in_kill=1 with in_data 0xAA -> the handshake completes, and 0xAA never asserts out_valid.
REQ-037 rst pulsed mid-stream with 2 items held -> out_valid=0 and in_ready=1 immediately, with no retirement of old items afterwards.
REQ-038 With PIPE_ELASTIC_STATS_EN, full pipe and out_ready=0 for 5 cycles -> occupancy=3 and stall_cnt=5; preload stall_cnt at 0xFFFFFFFE, stall 3 cycles -> it stays at 0xFFFFFFFF.
